memory_layer_feeder: RTL and testbench



---
 rtl/memory_layer_feeder_if.sv | 34 +++
 rtl/memory_layer_feeder.sv | 150 +++++++++++++++
 tb/tb_memory_layer_feeder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_layer_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_layer_feeder_if                                                     |
// | Host sample channel plus the memory-layer issue/handshake signals.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface memory_layer_feeder_if #(
    parameter int VEC_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] in_x;
    logic [31:0]      in_c;
    logic             in_last;
    logic             mode;
    logic             ready_wait;
    logic [VEC_W-1:0] x;
    logic [31:0]      c;
    logic             learning_recall;
    logic             learning_done;

    // Host and memory-layer side: drives samples, mode and the layer handshake.
    modport master (
        output in_valid, in_x, in_c, in_last, mode, ready_wait,
        input  in_ready, x, c, learning_recall, learning_done
    );

    // Feeder side.
    modport slave (
        input  in_valid, in_x, in_c, in_last, mode, ready_wait,
        output in_ready, x, c, learning_recall, learning_done
    );
endinterface
`default_nettype wire

// File: rtl/memory_layer_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memory_layer_feeder                                                        |
// | Buffers host samples in a FIFO and issues them to the GAM memory layer,    |
// | paced by ready_wait; pulses learning_done at the end of a learning epoch.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module memory_layer_feeder #(
    parameter int DEPTH = 16,
    parameter int VEC_W = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    memory_layer_feeder_if.slave      bus,
    output logic                      busy,
    output logic [CW-1:0]             count
);

    localparam int   AW          = $clog2(DEPTH);
    localparam int   ENTRY_W     = VEC_W + 32 + 1;
    localparam logic LR_LEARNING = 1'b0;
    localparam logic RW_READY    = 1'b0;
    localparam logic RW_WAIT     = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_ACK   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic [VEC_W-1:0]   r_x;
    logic [31:0]        r_c;
    logic               r_last;
    logic               r_learning_recall;
    logic               r_learning_done;

    logic               w_in_ready;
    logic               w_push;
    logic               w_pop;

    // in_ready depends only on the registered count, never on ready_wait.
    assign w_in_ready = (r_count != CW'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_x, bus.in_c, bus.in_last};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && (bus.ready_wait == RW_READY)) begin
                    w_pop        = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.ready_wait == RW_WAIT) begin
                    w_state_next = S_ACK;
                end
            end
            S_ACK: begin
                if (bus.ready_wait == RW_READY) begin
                    if (r_last && (r_learning_recall == LR_LEARNING)) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Mode is sampled every IDLE cycle, so a pop on the same edge carries the new mode.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x               <= '0;
            r_c               <= '0;
            r_last            <= 1'b0;
            r_learning_recall <= LR_LEARNING;
            r_learning_done   <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_learning_recall <= bus.mode;
            end
            if (w_pop) begin
                {r_x, r_c, r_last} <= r_mem[r_rd_ptr];
            end
            r_learning_done <= (w_state_next == S_DONE);
        end
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.x               = r_x;
    assign bus.c               = r_c;
    assign bus.learning_recall = r_learning_recall;
    assign bus.learning_done   = r_learning_done;
    assign busy                = (r_state != S_IDLE);
    assign count               = r_count;

endmodule
`default_nettype wire

// File: tb/tb_memory_layer_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_memory_layer_feeder                                                     |
// | Directed, scoreboard-checked bench for memory_layer_feeder.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_memory_layer_feeder;

    localparam int   DEPTH       = 16;
    localparam int   VEC_W       = 32;
    localparam int   CW          = $clog2(DEPTH + 1);
    localparam logic LR_LEARNING = 1'b0;
    localparam logic LR_RECALL   = 1'b1;
    localparam logic RW_READY    = 1'b0;
    localparam logic RW_WAIT     = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          busy;
    logic [CW-1:0] count;

    memory_layer_feeder_if #(.VEC_W(VEC_W)) bus ();

    memory_layer_feeder #(
        .DEPTH (DEPTH),
        .VEC_W (VEC_W),
        .CW    (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy),
        .count (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [VEC_W-1:0] x;
        logic [31:0]      c;
    } samp_t;

    samp_t sb[$];
    int    total     = 0;
    int    bad       = 0;
    int    done_cnt  = 0;
    int    seq       = 100;
    logic  prev_busy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and score any newly issued sample.
    task automatic tick();
        samp_t e;
        @(posedge clk);
        #1;
        if (bus.learning_done === 1'b1) done_cnt++;
        if (busy === 1'b1 && prev_busy === 1'b0) begin
            if (sb.size() == 0) begin
                chk("issue_unexpected", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                chk("issue_x", 64'(bus.x), 64'(e.x));
                chk("issue_c", 64'(bus.c), 64'(e.c));
            end
        end
        prev_busy = busy;
    endtask

    task automatic push(input logic [VEC_W-1:0] vx, input logic [31:0] vc,
                        input logic vl, input logic exp_acc);
        samp_t s;
        bus.in_valid = 1'b1;
        bus.in_x     = vx;
        bus.in_c     = vc;
        bus.in_last  = vl;
        chk("in_ready", 64'(bus.in_ready), 64'(exp_acc));
        if (exp_acc) begin
            s.x = vx;
            s.c = vc;
            sb.push_back(s);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Emulate the memory layer for one sample: WAIT for nwait cycles, then READY.
    task automatic serve(input int nwait, input logic exp_done);
        int n = 0;
        bus.ready_wait = RW_READY;
        while (busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("serve_start", 64'(busy), 64'd1);
        bus.ready_wait = RW_WAIT;
        repeat (nwait) tick();
        bus.ready_wait = RW_READY;
        tick();
        chk("done_pulse", 64'(bus.learning_done), 64'(exp_done));
        if (exp_done) tick();
        chk("serve_end_busy", 64'(busy), 64'd0);
        chk("serve_end_done", 64'(bus.learning_done), 64'd0);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_x       = '0;
        bus.in_c       = '0;
        bus.in_last    = 1'b0;
        bus.mode       = LR_LEARNING;
        bus.ready_wait = RW_READY;
        reset          = 1'b1;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_x", 64'(bus.x), 64'd0);
        chk("rst_c", 64'(bus.c), 64'd0);
        chk("rst_lr", 64'(bus.learning_recall), 64'(LR_LEARNING));
        chk("rst_done", 64'(bus.learning_done), 64'd0);
        reset = 1'b0;
        tick();

        // First sample: pushed at edge N, popped and presented at edge N+1.
        push(32'hA5A5_0001, 32'd3, 1'b0, 1'b1);
        chk("lat_count_after_push", 64'(count), 64'd1);
        chk("lat_busy_after_push", 64'(busy), 64'd0);
        tick();
        chk("lat_x", 64'(bus.x), 64'h0000_0000_A5A5_0001);
        chk("lat_c", 64'(bus.c), 64'd3);
        chk("lat_busy", 64'(busy), 64'd1);
        chk("lat_count_after_pop", 64'(count), 64'd0);

        // Layer stays READY: FSM must hold in ISSUE with x stable.
        repeat (4) tick();
        chk("hold_busy", 64'(busy), 64'd1);
        chk("hold_x", 64'(bus.x), 64'h0000_0000_A5A5_0001);
        bus.ready_wait = RW_WAIT;
        repeat (5) tick();
        chk("ack_busy", 64'(busy), 64'd1);
        chk("ack_x", 64'(bus.x), 64'h0000_0000_A5A5_0001);
        bus.ready_wait = RW_READY;
        tick();
        chk("ack_exit_busy", 64'(busy), 64'd0);
        chk("ack_exit_done", 64'(bus.learning_done), 64'd0);
        chk("idle_x_kept", 64'(bus.x), 64'h0000_0000_A5A5_0001);

        // Learning epoch of three samples ending with in_last.
        push($urandom, 32'd1, 1'b0, 1'b1);
        push($urandom, 32'd2, 1'b0, 1'b1);
        chk("push_pop_same_edge", 64'(count), 64'd1);
        push($urandom, 32'd3, 1'b1, 1'b1);
        chk("epoch_count", 64'(count), 64'd2);
        serve(2, 1'b0);
        serve(2, 1'b0);
        serve(2, 1'b1);
        chk("epoch_done_cnt", 64'(done_cnt), 64'd1);

        // Recall: mode is latched in IDLE before the next sample appears; no done pulse.
        bus.mode = LR_RECALL;
        push($urandom, 32'd9, 1'b1, 1'b1);
        chk("recall_lr", 64'(bus.learning_recall), 64'(LR_RECALL));
        chk("recall_c_before_issue", 64'(bus.c), 64'd3);
        serve(1, 1'b0);
        chk("recall_done_cnt", 64'(done_cnt), 64'd1);
        bus.mode = LR_LEARNING;
        tick();
        chk("back_to_learning", 64'(bus.learning_recall), 64'(LR_LEARNING));

        // Fill to full while the layer holds WAIT; the two extra pushes are refused.
        bus.ready_wait = RW_WAIT;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push($urandom, 32'(seq), 1'b0, (i < DEPTH));
            seq++;
        end
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        // Push offered at full with a pop: in_ready is still 0, so only the pop lands.
        bus.ready_wait = RW_READY;
        push($urandom, 32'(seq), 1'b0, 1'b0);
        seq++;
        chk("full_pop_count", 64'(count), 64'(DEPTH - 1));
        bus.ready_wait = RW_WAIT;
        tick();
        bus.ready_wait = RW_READY;
        tick();
        push($urandom, 32'(seq), 1'b0, 1'b1);
        seq++;
        chk("push_pop_nonfull", 64'(count), 64'(DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) serve(1, 1'b0);
        chk("drained_count", 64'(count), 64'd0);

        // More traffic so both pointers wrap repeatedly; order is checked on issue.
        for (int b = 0; b < 2; b++) begin
            bus.ready_wait = RW_WAIT;
            for (int i = 0; i < 12; i++) begin
                push($urandom, 32'(seq), 1'b0, 1'b1);
                seq++;
            end
            for (int i = 0; i < 12; i++) serve(1, 1'b0);
        end
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while in ACK with a last sample in flight and 5 queued.
        bus.ready_wait = RW_WAIT;
        push($urandom, 32'(seq), 1'b1, 1'b1);
        seq++;
        for (int i = 0; i < 5; i++) begin
            push($urandom, 32'(seq), 1'b0, 1'b1);
            seq++;
        end
        bus.ready_wait = RW_READY;
        tick();
        bus.ready_wait = RW_WAIT;
        tick();
        chk("pre_rst_count", 64'(count), 64'd5);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset          = 1'b1;
        bus.ready_wait = RW_READY;
        tick();
        reset = 1'b0;
        sb.delete();
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_x", 64'(bus.x), 64'd0);
        chk("mid_rst_c", 64'(bus.c), 64'd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (3) tick();
        chk("mid_rst_no_done", 64'(done_cnt), 64'd1);
        chk("mid_rst_idle_busy", 64'(busy), 64'd0);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
